pong_game_ctl: RTL and testbench

//  Parametrised game-flow controller for the Pong top level; replaces ad-hoc score logic in ball control.

---
 rtl/pong_game_ctl.sv | 222 ++++++++++++++++++++++
 tb/tb_pong_game_ctl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctl.sv
// rtl/pong_game_ctl.sv - Pong game-flow controller: score tracking and idle/serve/play/pause/point/over sequencing
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   frame_tick   one-cycle pulse per video frame (paces the serve delay)
//   start        start/restart request level, rising edge acts
//   pause        pause toggle request level, rising edge acts
//   goal         goal[i] one-cycle pulse: player i scored
//   scores       packed scores, player i at [i*SCORE_W +: SCORE_W]
//   state        IDLE=0 SERVE=1 PLAY=2 PAUSE=3 POINT=4 OVER=5
//   ball_run     ball may move (PLAY only)
//   ball_reset   one-cycle pulse to recentre the ball on every new serve
//   serve_idx    player who won the last point
//   winner       winning player index, winner_valid high while in OVER
module pong_game_ctl #(
  parameter int N_PLAYERS    = 2,
  parameter int SCORE_W      = 7,
  parameter int WIN_SCORE    = 11,
  parameter int WIN_MARGIN   = 2,
  parameter int SERVE_FRAMES = 60,
  localparam int IDX_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic                           start,
  input  logic                           pause,
  input  logic [N_PLAYERS-1:0]           goal,
  output logic [N_PLAYERS*SCORE_W-1:0]   scores,
  output logic [2:0]                     state,
  output logic                           ball_run,
  output logic                           ball_reset,
  output logic [IDX_W-1:0]               serve_idx,
  output logic [IDX_W-1:0]               winner,
  output logic                           winner_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  // Win comparison runs one bit wider than the score so score+margin cannot wrap.
  localparam logic [SCORE_W:0]   C_WIN      = WIN_SCORE[SCORE_W:0];
  localparam logic [SCORE_W:0]   C_MARGIN   = WIN_MARGIN[SCORE_W:0];
  localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] C_SAT      = {SCORE_W{1'b1}};

  state_t             r_state;
  state_t             r_src;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_start_q;
  logic               r_pause_q;
  logic [SCORE_W-1:0] r_score [N_PLAYERS];
  logic               r_ball_run;
  logic               r_ball_reset;
  logic [IDX_W-1:0]   r_serve_idx;
  logic [IDX_W-1:0]   r_winner;
  logic               r_winner_valid;

  state_t             w_state_nxt;
  state_t             w_src_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_clear;
  logic               w_inc;
  logic               w_brst_nxt;
  logic [IDX_W-1:0]   w_serve_nxt;
  logic [IDX_W-1:0]   w_winner_nxt;
  logic               w_wv_nxt;
  logic               w_start_edge;
  logic               w_pause_edge;
  logic               w_goal_any;
  logic [IDX_W-1:0]   w_goal_idx;
  logic [SCORE_W:0]   w_lead_score;
  logic               w_win;

  assign w_start_edge = start & ~r_start_q;
  assign w_pause_edge = pause & ~r_pause_q;
  assign w_goal_any   = |goal;

  // Lowest set goal bit wins; scanning downward leaves the lowest index last.
  always_comb begin
    w_goal_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (goal[i]) w_goal_idx = IDX_W'(i);
    end
  end

  // Evaluated in POINT, where serve_idx already names the player who just scored.
  always_comb begin
    w_lead_score = {1'b0, r_score[r_serve_idx]};
    w_win        = (w_lead_score >= C_WIN);
    for (int j = 0; j < N_PLAYERS; j++) begin
      if ((IDX_W'(j) != r_serve_idx) &&
          (w_lead_score < ({1'b0, r_score[j]} + C_MARGIN)))
        w_win = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_src_nxt    = r_src;
    w_cnt_nxt    = r_cnt;
    w_clear      = 1'b0;
    w_inc        = 1'b0;
    w_brst_nxt   = 1'b0;
    w_serve_nxt  = r_serve_idx;
    w_winner_nxt = r_winner;
    w_wv_nxt     = r_winner_valid;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = S_SERVE;
          w_clear     = 1'b1;
          w_brst_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      S_SERVE: begin
        // Pause takes precedence; a coincident frame tick is not counted.
        if (w_pause_edge) begin
          w_src_nxt   = S_SERVE;
          w_state_nxt = S_PAUSE;
        end else if (frame_tick) begin
          if (r_cnt == C_CNT_LAST) begin
            w_state_nxt = S_PLAY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (w_goal_any) begin
          w_inc       = 1'b1;
          w_serve_nxt = w_goal_idx;
          w_state_nxt = S_POINT;
        end else if (w_pause_edge) begin
          w_src_nxt   = S_PLAY;
          w_state_nxt = S_PAUSE;
        end
      end
      S_POINT: begin
        if (w_win) begin
          w_state_nxt  = S_OVER;
          w_winner_nxt = r_serve_idx;
          w_wv_nxt     = 1'b1;
        end else begin
          w_state_nxt = S_SERVE;
          w_brst_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      S_PAUSE: begin
        if (w_pause_edge) w_state_nxt = r_src;
      end
      S_OVER: begin
        if (w_start_edge) begin
          w_state_nxt = S_SERVE;
          w_clear     = 1'b1;
          w_wv_nxt    = 1'b0;
          w_brst_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_src          <= S_SERVE;
      r_cnt          <= '0;
      r_start_q      <= 1'b0;
      r_pause_q      <= 1'b0;
      r_ball_run     <= 1'b0;
      r_ball_reset   <= 1'b0;
      r_serve_idx    <= '0;
      r_winner       <= '0;
      r_winner_valid <= 1'b0;
      for (int i = 0; i < N_PLAYERS; i++) r_score[i] <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_src          <= w_src_nxt;
      r_cnt          <= w_cnt_nxt;
      r_start_q      <= start;
      r_pause_q      <= pause;
      r_ball_run     <= (w_state_nxt == S_PLAY);
      r_ball_reset   <= w_brst_nxt;
      r_serve_idx    <= w_serve_nxt;
      r_winner       <= w_winner_nxt;
      r_winner_valid <= w_wv_nxt;
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (w_clear)
          r_score[i] <= '0;
        else if (w_inc && (w_goal_idx == IDX_W'(i)) && (r_score[i] != C_SAT))
          r_score[i] <= r_score[i] + 1'b1;
      end
    end
  end

  genvar g_i;
  generate
    for (g_i = 0; g_i < N_PLAYERS; g_i++) begin : g_pack
      assign scores[g_i*SCORE_W +: SCORE_W] = r_score[g_i];
    end
  endgenerate

  assign state        = r_state;
  assign ball_run     = r_ball_run;
  assign ball_reset   = r_ball_reset;
  assign serve_idx    = r_serve_idx;
  assign winner       = r_winner;
  assign winner_valid = r_winner_valid;

endmodule

// File: tb/tb_pong_game_ctl.sv
// tb/tb_pong_game_ctl.sv - self-checking bench for pong_game_ctl
module tb_pong_game_ctl;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_PAUSE = 3'd3, S_POINT = 3'd4, S_OVER = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, frame_tick, start, pause;
  logic [1:0]  goal, goal_b;
  logic [13:0] scores;
  logic [2:0]  state;
  logic        ball_run, ball_reset, serve_idx, winner, winner_valid;
  logic [5:0]  scores_b;
  logic [2:0]  state_b;
  logic        ball_run_b, ball_reset_b, serve_idx_b, winner_b, winner_valid_b;

  pong_game_ctl #(.N_PLAYERS(2), .SCORE_W(7), .WIN_SCORE(11), .WIN_MARGIN(2), .SERVE_FRAMES(4)) u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause), .goal(goal),
    .scores(scores), .state(state), .ball_run(ball_run), .ball_reset(ball_reset),
    .serve_idx(serve_idx), .winner(winner), .winner_valid(winner_valid));

  pong_game_ctl #(.N_PLAYERS(2), .SCORE_W(3), .WIN_SCORE(7), .WIN_MARGIN(2), .SERVE_FRAMES(1)) u_dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause), .goal(goal_b),
    .scores(scores_b), .state(state_b), .ball_run(ball_run_b), .ball_reset(ball_reset_b),
    .serve_idx(serve_idx_b), .winner(winner_b), .winner_valid(winner_valid_b));

  typedef struct {
    logic       st, pa, tk;
    logic [1:0] g;
    logic       sel;
    logic [2:0] e_state;
    logic       e_run, e_brst;
    logic [6:0] e_s0, e_s1;
    logic       e_sidx, e_win, e_wv;
  } vec_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [21:0] exp_q[$];
  vec_t        tbl[$];
  int          m_s[2];
  logic        m_sidx, m_win, m_wv;

  function automatic vec_t mk(input logic st, pa, tk, input logic [1:0] g, input logic sel,
                              input logic [2:0] est, input logic erun, ebrst,
                              input logic [6:0] es0, es1, input logic esidx, ewin, ewv);
    vec_t v;
    v.st = st; v.pa = pa; v.tk = tk; v.g = g; v.sel = sel;
    v.e_state = est; v.e_run = erun; v.e_brst = ebrst;
    v.e_s0 = es0; v.e_s1 = es1; v.e_sidx = esidx; v.e_win = ewin; v.e_wv = ewv;
    return v;
  endfunction

  function automatic vec_t mm(input logic sel, st, pa, tk, input logic [1:0] g,
                              input logic [2:0] est, input logic erun, ebrst);
    return mk(st, pa, tk, g, sel, est, erun, ebrst, 7'(m_s[0]), 7'(m_s[1]), m_sidx, m_win, m_wv);
  endfunction

  function automatic logic [21:0] pack_exp(input vec_t v);
    return {v.e_state, v.e_run, v.e_brst, v.e_s0, v.e_s1, v.e_sidx, v.e_win, v.e_wv};
  endfunction

  function automatic logic [21:0] actual(input logic sel);
    if (sel)
      return {state_b, ball_run_b, ball_reset_b, 4'b0, scores_b[2:0], 4'b0, scores_b[5:3],
              serve_idx_b, winner_b, winner_valid_b};
    return {state, ball_run, ball_reset, scores[6:0], scores[13:7], serve_idx, winner, winner_valid};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got st=%0d run=%b brst=%b s0=%0d s1=%0d sidx=%b win=%b wv=%b, expected st=%0d run=%b brst=%b s0=%0d s1=%0d sidx=%b win=%b wv=%b",
               name, $time, act[21:19], act[18], act[17], act[16:10], act[9:3], act[2], act[1], act[0],
               exp[21:19], exp[18], exp[17], exp[16:10], exp[9:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of stimulus; the expected outputs are queued at drive time and
  // popped once the DUT has registered its response to that cycle.
  task automatic step(input vec_t v, input string name);
    logic [21:0] e;
    start      = v.st;
    pause      = v.pa;
    frame_tick = v.tk;
    goal       = v.sel ? 2'b00 : v.g;
    goal_b     = v.sel ? v.g : 2'b00;
    exp_q.push_back(pack_exp(v));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check(name, actual(v.sel), e);
  endtask

  task automatic model_reset();
    m_s[0] = 0; m_s[1] = 0; m_sidx = 1'b0; m_win = 1'b0; m_wv = 1'b0;
  endtask

  task automatic do_reset();
    start = 0; pause = 0; frame_tick = 0; goal = 0; goal_b = 0;
    rst = 1'b0;
    model_reset();
    #1;
    check("reset_a", actual(1'b0), '0);
    check("reset_b", actual(1'b1), '0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic start_game(input logic sel);
    m_s[0] = 0; m_s[1] = 0; m_wv = 1'b0;
    step(mm(sel, 1, 0, 0, 2'b00, S_SERVE, 0, 1), "start_serve");
    step(mm(sel, 0, 0, 0, 2'b00, S_SERVE, 0, 0), "start_settle");
  endtask

  task automatic serve_to_play(input logic sel);
    int n;
    n = sel ? 1 : 4;
    for (int k = 1; k < n; k++) step(mm(sel, 0, 0, 1, 2'b00, S_SERVE, 0, 0), "serve_wait");
    step(mm(sel, 0, 0, 1, 2'b00, S_PLAY, 1, 0), "serve_done");
  endtask

  task automatic goal_point(input logic sel, input int p);
    int         lim, ws;
    logic [1:0] g;
    bit         win;
    lim = sel ? 7 : 127;
    ws  = sel ? 7 : 11;
    g   = (p == 0) ? 2'b01 : 2'b10;
    if (m_s[p] < lim) m_s[p]++;
    m_sidx = (p != 0);
    step(mm(sel, 0, 0, 0, g, S_POINT, 0, 0), "goal_point");
    win = (m_s[p] >= ws) && (m_s[p] >= m_s[1-p] + 2);
    if (win) begin
      m_win = (p != 0);
      m_wv  = 1'b1;
      step(mm(sel, 0, 0, 0, 2'b00, S_OVER, 0, 0), "point_over");
    end else begin
      step(mm(sel, 0, 0, 0, 2'b00, S_SERVE, 0, 1), "point_serve");
    end
  endtask

  task automatic point(input logic sel, input int p);
    serve_to_play(sel);
    goal_point(sel, p);
  endtask

  initial begin
    // {start, pause, tick, goal, sel} -> {state, run, brst, s0, s1, sidx, winner, wv}
    tbl.push_back(mk(0,0,1,2'b00,0, S_IDLE ,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,2'b01,0, S_IDLE ,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,2'b00,0, S_SERVE,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,1,2'b00,0, S_SERVE,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'b00,0, S_SERVE,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'b00,0, S_SERVE,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,2'b00,0, S_SERVE,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'b00,0, S_PLAY ,1,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,2'b00,0, S_PLAY ,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,2'b11,0, S_POINT,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,2'b00,0, S_SERVE,0,1, 1,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'b00,0, S_SERVE,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'b00,0, S_SERVE,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,1,1,2'b00,0, S_PAUSE,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,1,1,2'b00,0, S_PAUSE,0,0, 1,0,0,0,0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(0,1,1,2'b00,0, S_PAUSE,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1,0,1,2'b00,0, S_PAUSE,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'b00,0, S_PAUSE,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,1,0,2'b01,0, S_SERVE,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,1,1,2'b00,0, S_SERVE,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'b00,0, S_PLAY ,1,0, 1,0,0,0,0));
    tbl.push_back(mk(0,1,0,2'b00,0, S_PAUSE,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,2'b10,0, S_PAUSE,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,1,0,2'b00,0, S_PLAY ,1,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,2'b00,0, S_PLAY ,1,0, 1,0,0,0,0));
    tbl.push_back(mk(0,1,0,2'b10,0, S_POINT,0,0, 1,1,1,0,0));
    tbl.push_back(mk(0,0,0,2'b00,0, S_SERVE,0,1, 1,1,1,0,0));
    tbl.push_back(mk(0,0,0,2'b00,0, S_SERVE,0,0, 1,1,1,0,0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Reach 5/3 in PLAY, then drop reset between clock edges.
    do_reset();
    start_game(1'b0);
    point(1'b0, 0); point(1'b0, 1); point(1'b0, 0); point(1'b0, 1);
    point(1'b0, 0); point(1'b0, 1); point(1'b0, 0); point(1'b0, 0);
    serve_to_play(1'b0);
    check("pre_reset_5_3", actual(1'b0), pack_exp(mm(1'b0, 0, 0, 0, 2'b00, S_PLAY, 1, 0)));
    #3 rst = 1'b0;
    #1 check("async_reset_mid_play", actual(1'b0), '0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // Game 1: 10-10, then 11-10 and 11-11 do not win, P1 wins 11-13.
    start_game(1'b0);
    for (int k = 0; k < 10; k++) begin point(1'b0, 0); point(1'b0, 1); end
    point(1'b0, 0); point(1'b0, 1); point(1'b0, 1); point(1'b0, 1);
    step(mm(1'b0, 0, 0, 0, 2'b01, S_OVER, 0, 0), "goal_in_over");
    step(mm(1'b0, 0, 0, 1, 2'b10, S_OVER, 0, 0), "tick_in_over");

    // Game 2 from OVER: 11-10 then P0 wins at 12-10.
    start_game(1'b0);
    for (int k = 0; k < 10; k++) begin point(1'b0, 1); point(1'b0, 0); end
    point(1'b0, 0); point(1'b0, 0);

    // Narrow scores: saturate at 7 and never reach OVER from 7-7.
    do_reset();
    start_game(1'b1);
    for (int k = 0; k < 7; k++) begin point(1'b1, 0); point(1'b1, 1); end
    point(1'b1, 0); point(1'b1, 0); point(1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
